// File: rtl/free_preg_list_if.sv
// Rename/retire-side signal bundle for the free physical register list.
// Optional FREE_LIST_DUP_CHECK_EN adds the dup_err status line.
`ifndef NUM_PREGS
`define NUM_PREGS 64
`endif
`ifndef NUM_AREGS
`define NUM_AREGS 32
`endif

interface free_preg_list_if #(
    parameter int NUM_PREGS = `NUM_PREGS,
    parameter int NUM_AREGS = `NUM_AREGS,
    parameter int DEPTH     = NUM_PREGS - NUM_AREGS
);
    localparam int PW = $clog2(NUM_PREGS);
    localparam int CW = $clog2(DEPTH + 1);

    logic          r_en;
    logic [PW-1:0] preg_out;
    logic          empty;
    logic          w_en;
    logic [PW-1:0] free_preg_in;
    logic          full;
    logic [CW-1:0] count;
`ifdef FREE_LIST_DUP_CHECK_EN
    logic          dup_err;
`endif

    modport slave (
        input  r_en, w_en, free_preg_in,
        output preg_out, empty, full, count
`ifdef FREE_LIST_DUP_CHECK_EN
        , output dup_err
`endif
    );

    modport master (
        output r_en, w_en, free_preg_in,
        input  preg_out, empty, full, count
`ifdef FREE_LIST_DUP_CHECK_EN
        , input dup_err
`endif
    );
endinterface

// File: rtl/free_preg_list.sv
// Circular FIFO of free physical register tags: retire pushes, rename pops the show-ahead head.
// Defining FREE_LIST_DUP_CHECK_EN adds an in_list vector that drops duplicate frees and pulses dup_err.
`ifndef NUM_PREGS
`define NUM_PREGS 64
`endif
`ifndef NUM_AREGS
`define NUM_AREGS 32
`endif

module free_preg_list #(
    parameter int NUM_PREGS = `NUM_PREGS,
    parameter int NUM_AREGS = `NUM_AREGS,
    parameter int DEPTH     = NUM_PREGS - NUM_AREGS
) (
    input  logic            clk,
    input  logic            rst,
    free_preg_list_if.slave bus
);
    localparam int PW   = $clog2(NUM_PREGS);
    localparam int CW   = $clog2(DEPTH + 1);
    localparam int PTRW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [PW-1:0]   mem_q [DEPTH];
    logic [PW-1:0]   mem_d [DEPTH];
    logic [PTRW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTRW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            empty;
    logic            full;
    logic            pop_ok;
    logic            push_ok;
    logic            push_legal;

`ifdef FREE_LIST_DUP_CHECK_EN
    logic [NUM_PREGS-1:0] in_list_q, in_list_d, in_list_pop;
    logic                 dup_err_q, dup_err_d;
    logic                 dup_hit;
`endif

    // Flags come only from the count register so rename never sees a same-cycle combinational path.
    assign empty        = (count_q == '0);
    assign full         = (count_q == CW'(DEPTH));
    assign bus.empty    = empty;
    assign bus.full     = full;
    assign bus.count    = count_q;
    assign bus.preg_out = mem_q[rd_ptr_q];

    function automatic logic [PTRW-1:0] ptr_inc(input logic [PTRW-1:0] p);
        return (p == PTRW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        pop_ok     = bus.r_en && !empty;
        // p0 backs x0 and must never re-enter the pool.
        push_legal = bus.w_en && (bus.free_preg_in != '0) && (!full || pop_ok);
`ifdef FREE_LIST_DUP_CHECK_EN
        in_list_pop = in_list_q;
        if (pop_ok) begin
            in_list_pop[bus.preg_out] = 1'b0;
        end
        dup_hit   = in_list_pop[bus.free_preg_in];
        push_ok   = push_legal && !dup_hit;
        dup_err_d = bus.w_en && (bus.free_preg_in != '0) && dup_hit;
        in_list_d = in_list_pop;
        if (push_ok) begin
            in_list_d[bus.free_preg_in] = 1'b1;
        end
`else
        push_ok = push_legal;
`endif

        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = bus.free_preg_in;
            wr_ptr_d        = ptr_inc(wr_ptr_q);
        end
        if (pop_ok) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= PW'(NUM_AREGS + i);
            end
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= CW'(DEPTH);
        end else begin
            mem_q    <= mem_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

`ifdef FREE_LIST_DUP_CHECK_EN
    assign bus.dup_err = dup_err_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_PREGS; i++) begin
                in_list_q[i] <= (i >= NUM_AREGS);
            end
            dup_err_q <= 1'b0;
        end else begin
            in_list_q <= in_list_d;
            dup_err_q <= dup_err_d;
        end
    end
`endif
endmodule

// File: tb/tb_free_preg_list.sv
// Directed bench for free_preg_list: vector table plus hand-written wrap, drop, async-reset and duplicate sequences.
// Build with FREE_LIST_DUP_CHECK_EN defined to also exercise the duplicate-free check.
module tb_free_preg_list;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    free_preg_list_if #(.NUM_PREGS(64), .NUM_AREGS(32), .DEPTH(32)) bus ();

    free_preg_list #(.NUM_PREGS(64), .NUM_AREGS(32), .DEPTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic       r_en;
        logic       w_en;
        logic [5:0] tag;
        int         exp_count;
        logic       exp_empty;
        logic       exp_full;
        logic       chk_preg;
        int         exp_preg;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(string n, logic r, logic w, int t, int c, logic e, logic f,
                                logic cp, int p);
        vec_t v;
        v.name = n; v.r_en = r; v.w_en = w; v.tag = 6'(t);
        v.exp_count = c; v.exp_empty = e; v.exp_full = f; v.chk_preg = cp; v.exp_preg = p;
        return v;
    endfunction

    task automatic check(string name, int act, int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step(logic r, logic w, int t);
        bus.r_en         = r;
        bus.w_en         = w;
        bus.free_preg_in = 6'(t);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        bus.r_en = 1'b0; bus.w_en = 1'b0; bus.free_preg_in = '0;
        rst = 1'b0;
        #1;
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic check_state(string name, int c, logic e, logic f);
        check({name, ".count"}, int'(bus.count), c);
        check({name, ".empty"}, int'(bus.empty), int'(e));
        check({name, ".full"},  int'(bus.full),  int'(f));
    endtask

    initial begin
        bus.r_en = 1'b0; bus.w_en = 1'b0; bus.free_preg_in = '0;

        vecs.push_back(mk("idle", 0, 0, 0, 32, 0, 1, 1, 32));
        for (int k = 1; k <= 32; k++)
            vecs.push_back(mk("pop", 1, 0, 0, 32 - k, (k == 32), 0, (k < 32), 32 + k));
        vecs.push_back(mk("pop_on_empty", 1, 0, 0, 0, 1, 0, 0, 0));
        vecs.push_back(mk("push_on_empty", 1, 1, 5, 1, 0, 0, 1, 5));
        vecs.push_back(mk("push_zero", 0, 1, 0, 1, 0, 0, 1, 5));
        vecs.push_back(mk("push_pop_one", 1, 1, 9, 1, 0, 0, 1, 9));
        vecs.push_back(mk("pop_last", 1, 0, 0, 0, 1, 0, 0, 0));

        #2 rst = 1'b0;
        #1;
        check_state("reset_async", 32, 0, 1);
        check("reset_async.preg", int'(bus.preg_out), 32);
        @(negedge clk);
        rst = 1'b1;

        foreach (vecs[i]) begin
            step(vecs[i].r_en, vecs[i].w_en, int'(vecs[i].tag));
            check_state(vecs[i].name, vecs[i].exp_count, vecs[i].exp_empty, vecs[i].exp_full);
            if (vecs[i].chk_preg)
                check({vecs[i].name, ".preg"}, int'(bus.preg_out), vecs[i].exp_preg);
        end

        // Full list: push 40 alongside a pop, then read it back after 63 on wrap.
        do_reset();
        check("wrap.head_popped", int'(bus.preg_out), 32);
        step(1, 1, 40);
        check_state("wrap.push_pop", 32, 0, 1);
        check("wrap.preg", int'(bus.preg_out), 33);
        for (int j = 1; j <= 31; j++) begin
            step(1, 0, 0);
            check("wrap.seq", int'(bus.preg_out), (j < 31) ? 33 + j : 40);
        end
        check_state("wrap.end", 1, 0, 0);

        // Push while full without a pop is dropped and leaves storage untouched.
        do_reset();
        step(0, 1, 50);
        check_state("full_drop", 32, 0, 1);
        check("full_drop.preg", int'(bus.preg_out), 32);
        for (int k = 1; k <= 32; k++) begin
            step(1, 0, 0);
            if (k < 32) check("full_drop.seq", int'(bus.preg_out), 32 + k);
        end
        check_state("full_drop.end", 0, 1, 0);

        // Asynchronous reset mid-stream with count=7, requests still asserted.
        do_reset();
        for (int k = 0; k < 25; k++) step(1, 0, 0);
        check_state("pre_async", 7, 0, 0);
        bus.w_en = 1'b1; bus.free_preg_in = 6'd12;
        #2 rst = 1'b0;
        #1;
        check_state("async_rst", 32, 0, 1);
        check("async_rst.preg", int'(bus.preg_out), 32);
        @(negedge clk);
        bus.r_en = 1'b0; bus.w_en = 1'b0;
        rst = 1'b1;

`ifdef FREE_LIST_DUP_CHECK_EN
        do_reset();
        check("dup.reset", int'(bus.dup_err), 0);
        step(1, 0, 0);
        check_state("dup.pop", 31, 0, 0);
        step(0, 1, 33);
        check("dup.err", int'(bus.dup_err), 1);
        check_state("dup.drop", 31, 0, 0);
        step(0, 0, 0);
        check("dup.err_clear", int'(bus.dup_err), 0);
        step(0, 1, 32);
        check("dup.ok_err", int'(bus.dup_err), 0);
        check_state("dup.ok", 32, 0, 1);
        check("dup.head", int'(bus.preg_out), 33);
        step(1, 1, 33);
        check("dup.same_tag_err", int'(bus.dup_err), 0);
        check_state("dup.same_tag", 32, 0, 1);
        for (int k = 0; k < 30; k++) step(1, 0, 0);
        check("dup.tail_32", int'(bus.preg_out), 32);
        step(1, 0, 0);
        check("dup.tail_33", int'(bus.preg_out), 33);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
